time_report_encoder: RTL
========================

// Module: time_report_encoder
// PURPOSE
//  Transmit-side counterpart of the UART command decoder: on a report request, snapshots the
//  current time fields (stopwatch or watch) and serialises them as an ASCII frame into the
//  UART TX FIFO push port. Sits between the stopwatch/watch datapath and uart_top's TX FIFO.
//  Frame: <tag>HH:MM:SS.CC<EOL>, e.g. "S12:34:56.78\r\n"; tag 'S'(0x53) stopwatch, 'W'(0x57) watch.
// PARAMETERS
//  EOL_CRLF   1   1: EOL = 0x0D,0x0A (14-byte frame); 0: EOL = 0x0A only (13-byte frame)
// PORTS
//  clk            in   1  system clock; single clock domain
//  rst            in   1  asynchronous, active-low reset (0 = reset asserted)
//  report_trigger in   1  1-cycle request pulse (decoder output or button edge)
//  mode_sel       in   1  0 = stopwatch tag 'S', 1 = watch tag 'W'; sampled with trigger
//  i_hour         in   5  hours, binary
//  i_min          in   6  minutes, binary
//  i_sec          in   6  seconds, binary
//  i_cent         in   7  centiseconds, binary
//  tx_full        in   1  TX FIFO full; no push while high
//  tx_push        out  1  1-cycle push strobe per byte
//  tx_pushdata    out  8  ASCII byte, valid when tx_push=1
//  busy           out  1  frame in progress
//  dropped        out  1  1-cycle pulse: trigger arrived while busy and was ignored
// BEHAVIOUR
//  - Reset: state IDLE, byte index 0, snapshot regs 0; tx_push=0, tx_pushdata=0x00, busy=0, dropped=0.
//  - FSM IDLE -> SEND: on report_trigger=1 at edge N, latch mode_sel + all four fields; busy=1 from N+1.
//  - SEND: tx_push = !tx_full (combinational on registered state + tx_full only; no path from
//    report_trigger). Byte index advances only on a cycle with tx_push=1. tx_full high stalls
//    indefinitely with index and tx_pushdata held stable.
//  - First byte pushed at earliest in cycle N+1; unstalled frame occupies exactly 14 (13) cycles.
//  - After last EOL byte pushed at edge M: state IDLE, busy=0 from M+1. New trigger accepted at M+1.
//  - Trigger in SEND (incl. cycle of last push): ignored, dropped=1 next cycle; frame unaffected.
//  - Live inputs may change during SEND; frame always reflects the snapshot at acceptance.
//  - Byte order: tag, Htens, Hunits, ':', Mt, Mu, ':', St, Su, '.', Ct, Cu, [0x0D], 0x0A.
//  - Digit conversion: tens = v/10, units = v%10, ASCII = 0x30 + digit. Any field value > 99
//    saturates to "99" (no wrap, no non-digit characters). Leading zeros always printed ("05").
//  - Reset asserted mid-frame: immediate return to IDLE; remaining bytes never pushed; no
//    partial-frame resume after release.
// STRUCTURE
//  - Shared package: ASCII constants (ASC_0, ASC_COLON, ASC_DOT, ASC_CR, ASC_LF, ASC_S, ASC_W),
//    FSM state encoding (ST_IDLE, ST_SEND), frame-length constant derived from EOL_CRLF.
//  - One sub-module: bin2ascii_2digit (7-bit binary in -> two ASCII bytes, saturating at 99),
//    instantiated 4x on snapshot registers; top holds FSM, index counter, byte mux.
// TESTING
//  - Trigger, mode_sel=0, 12/34/56/78, tx_full=0 -> 14 consecutive pushes "S12:34:56.78\r\n", busy 14 cycles.
//  - mode_sel=1, 0/5/9/0, EOL_CRLF=0 -> "W00:05:09.00\n", 13 pushes, no 0x0D.
//  - tx_full held high 5 cycles after byte 3 -> no push, tx_pushdata stable ':' ; resumes, full frame intact.
//  - Second trigger mid-frame and in last-push cycle -> dropped pulses, exactly one frame output.
//  - i_cent=120, i_min=63 -> "..:63:..99" i.e. cent saturates to "99", min prints "63".
//  - rst=0 after byte 6 -> tx_push=0, busy=0 immediately; after release, new trigger emits a full fresh frame.

Source files
------------

// File: rtl/time_report_encoder_pkg.sv
// rtl/time_report_encoder_pkg.sv - shared constants for the time report frame encoder
package time_report_encoder_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_W     = 8'h57;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // CRLF frames carry one extra byte (0x0D) ahead of the final 0x0A
    function automatic logic [3:0] frame_len(input bit eol_crlf);
        return eol_crlf ? 4'd14 : 4'd13;
    endfunction

endpackage

// File: rtl/bin2ascii_2digit.sv
// rtl/bin2ascii_2digit.sv - 7-bit binary to two ASCII decimal digits, saturating at 99
module bin2ascii_2digit
    import time_report_encoder_pkg::*;
(
    input  logic [6:0] value,
    output logic [7:0] tens_ascii,
    output logic [7:0] units_ascii
);

    logic [6:0] sat;
    logic [6:0] tens;
    logic [6:0] units;

    always_comb begin
        sat         = (value > 7'd99) ? 7'd99 : value;
        tens        = sat / 7'd10;
        units       = sat % 7'd10;
        tens_ascii  = ASC_0 + {1'b0, tens};
        units_ascii = ASC_0 + {1'b0, units};
    end

endmodule

// File: rtl/time_report_encoder.sv
// rtl/time_report_encoder.sv - snapshots time fields and pushes "<tag>HH:MM:SS.CC<EOL>" into a TX FIFO
module time_report_encoder
    import time_report_encoder_pkg::*;
#(
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       report_trigger,
    input  logic       mode_sel,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_cent,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_pushdata,
    output logic       busy,
    output logic       dropped
);

    localparam logic [3:0] LAST_IDX = frame_len(EOL_CRLF) - 4'd1;

    logic [0:0] state;
    logic [3:0] idx;
    logic       snap_mode;
    logic [4:0] snap_hour;
    logic [5:0] snap_min;
    logic [5:0] snap_sec;
    logic [6:0] snap_cent;

    logic [7:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u, cent_t, cent_u;
    logic [7:0] byte_sel;

    bin2ascii_2digit u_hour (.value({2'b00, snap_hour}), .tens_ascii(hour_t), .units_ascii(hour_u));
    bin2ascii_2digit u_min  (.value({1'b0, snap_min}),   .tens_ascii(min_t),  .units_ascii(min_u));
    bin2ascii_2digit u_sec  (.value({1'b0, snap_sec}),   .tens_ascii(sec_t),  .units_ascii(sec_u));
    bin2ascii_2digit u_cent (.value(snap_cent),          .tens_ascii(cent_t), .units_ascii(cent_u));

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            4'd0:    byte_sel = snap_mode ? ASC_W : ASC_S;
            4'd1:    byte_sel = hour_t;
            4'd2:    byte_sel = hour_u;
            4'd3:    byte_sel = ASC_COLON;
            4'd4:    byte_sel = min_t;
            4'd5:    byte_sel = min_u;
            4'd6:    byte_sel = ASC_COLON;
            4'd7:    byte_sel = sec_t;
            4'd8:    byte_sel = sec_u;
            4'd9:    byte_sel = ASC_DOT;
            4'd10:   byte_sel = cent_t;
            4'd11:   byte_sel = cent_u;
            4'd12:   byte_sel = EOL_CRLF ? ASC_CR : ASC_LF;
            4'd13:   byte_sel = ASC_LF;
            default: byte_sel = 8'h00;
        endcase
    end

    // Push depends only on registered state and back-pressure, never on the trigger
    assign busy        = (state == ST_SEND);
    assign tx_push     = busy && !tx_full;
    assign tx_pushdata = busy ? byte_sel : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= 4'd0;
            snap_mode <= 1'b0;
            snap_hour <= 5'd0;
            snap_min  <= 6'd0;
            snap_sec  <= 6'd0;
            snap_cent <= 7'd0;
            dropped   <= 1'b0;
        end else if (state == ST_IDLE) begin
            dropped <= 1'b0;
            if (report_trigger) begin
                state     <= ST_SEND;
                idx       <= 4'd0;
                snap_mode <= mode_sel;
                snap_hour <= i_hour;
                snap_min  <= i_min;
                snap_sec  <= i_sec;
                snap_cent <= i_cent;
            end
        end else begin
            dropped <= report_trigger;
            if (tx_push) begin
                if (idx == LAST_IDX) begin
                    state <= ST_IDLE;
                    idx   <= 4'd0;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule
